sha256_message_padder: RTL and testbench

Streaming SHA-256 message padder for the hashing datapath. It accepts a message length in 32-bit words, reports the padded block count, then emits the fully padded message one word per handshake. The padded stream is: message words, the 0x80000000 marker, zero fill, and the 64-bit bit-length. It sits between the message-word fetch logic and the per-block compression engine. It replaces the purely combinational block-count calculation with a block that both counts and produces the padding.

---
 rtl/sha256_pad_pkg.sv | 26 ++
 rtl/sha256_block_count.sv | 29 ++
 rtl/sha256_message_padder.sv | 225 ++++++++++++++++++++++
 tb/tb_sha256_message_padder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pad_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pad_pkg
// Shared definitions for the streaming SHA-256 message padder:
//   pad_state_t     - padder FSM states
//   PAD_MARKER      - the single '1' bit that terminates the message
//   WORDS_PER_BLOCK - 32-bit words per 512-bit SHA-256 block
//   LEN_HI_IDX      - word index of the upper half of the 64-bit length
// No ports (package).
// -----------------------------------------------------------------------------
package sha256_pad_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MSG    = 3'd1,
    PAD1   = 3'd2,
    ZERO   = 3'd3,
    LEN_HI = 3'd4,
    LEN_LO = 3'd5,
    FLUSH  = 3'd6
  } pad_state_t;

  localparam logic [31:0] PAD_MARKER      = 32'h8000_0000;
  localparam int          WORDS_PER_BLOCK = 16;
  localparam int          LEN_HI_IDX      = 14;

endpackage

// File: rtl/sha256_block_count.sv
// -----------------------------------------------------------------------------
// sha256_block_count
// Combinational count of 512-bit blocks needed to pad a message of `size`
// 32-bit words: the message plus the marker word plus two length words,
// rounded up to a whole number of 16-word blocks.
// Ports:
//   size       in  SIZE_W  message length in 32-bit words
//   num_blocks out BLK_W   ceil((size + 3) / 16)
// The sum is formed one bit wider than size so size + 3 never overflows.
// -----------------------------------------------------------------------------
module sha256_block_count #(
  parameter  int SIZE_W = 16,
  localparam int BLK_W  = SIZE_W - 3
) (
  input  logic [SIZE_W-1:0] size,
  output logic [BLK_W-1:0]  num_blocks
);

  logic [SIZE_W:0] padded_s;
  logic            partial_s;

  // Round (size + 3) words up to whole 16-word blocks
  always_comb begin
    padded_s   = {1'b0, size} + (SIZE_W + 1)'(3);
    partial_s  = (padded_s[3:0] != 4'h0);
    num_blocks = padded_s[SIZE_W:4] + BLK_W'(partial_s);
  end

endmodule

// File: rtl/sha256_message_padder.sv
// -----------------------------------------------------------------------------
// sha256_message_padder
// Streaming SHA-256 padder. On an accepted start it latches the message size
// and block count, then emits: the message words (passed through from the
// input stream), 0x80000000, zero fill up to word 13 of a block, and the
// 64-bit message bit-length in words 14 and 15 of the final block.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, size                one-cycle request (IDLE only) and length in words
//   num_blocks, busy, done     block count, activity flag, completion pulse
//   in_valid/in_ready/in_data  message word stream (consumed only in MSG)
//   out_valid/out_ready/out_data, out_block_last, out_msg_last
//                              padded word stream from a single register stage
// -----------------------------------------------------------------------------
module sha256_message_padder
  import sha256_pad_pkg::*;
#(
  parameter  int SIZE_W = 16,
  localparam int BLK_W  = SIZE_W - 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  output logic [BLK_W-1:0]  num_blocks,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_block_last,
  output logic              out_msg_last
);

  localparam logic [3:0] LAST_IDX    = 4'(WORDS_PER_BLOCK - 1);
  localparam logic [3:0] PRE_LEN_IDX = 4'(LEN_HI_IDX - 1);

  pad_state_t        state_r, state_next_s;
  logic [SIZE_W-1:0] size_r;
  logic [BLK_W-1:0]  num_blocks_r;
  logic              busy_r;
  logic              done_r;
  logic [3:0]        word_idx_r;
  logic [SIZE_W-1:0] msg_cnt_r;
  logic [BLK_W-1:0]  blk_cnt_r;
  logic              out_valid_r;
  logic [31:0]       out_data_r;
  logic              out_block_last_r;
  logic              out_msg_last_r;

  logic [BLK_W-1:0]  blk_s;
  logic [63:0]       bit_len_s;
  logic              load_s;
  logic              emit_s;
  logic [31:0]       word_s;
  logic              in_ready_s;
  logic              accept_start_s;
  logic              final_ack_s;

  sha256_block_count #(.SIZE_W(SIZE_W)) u_block_count (
    .size       (size),
    .num_blocks (blk_s)
  );

  // Output register can take a new word when empty or being drained this cycle
  assign load_s         = !out_valid_r || out_ready;
  assign bit_len_s      = 64'({size_r, 5'b00000});
  assign accept_start_s = (state_r == IDLE) && start;
  // The LEN_LO word is the only word still held in FLUSH
  assign final_ack_s    = (state_r == FLUSH) && out_valid_r && out_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and selection of the word to emit
  always_comb begin
    state_next_s = state_r;
    emit_s       = 1'b0;
    word_s       = 32'h0000_0000;
    in_ready_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = (size != SIZE_W'(0)) ? MSG : PAD1;
        end else begin
          state_next_s = IDLE;
        end
      end
      MSG: begin
        in_ready_s = load_s;
        if (load_s && in_valid) begin
          emit_s = 1'b1;
          word_s = in_data;
          if ((msg_cnt_r + SIZE_W'(1)) == size_r) begin
            state_next_s = PAD1;
          end else begin
            state_next_s = MSG;
          end
        end else begin
          state_next_s = MSG;
        end
      end
      PAD1: begin
        word_s = PAD_MARKER;
        if (load_s) begin
          emit_s       = 1'b1;
          state_next_s = (word_idx_r == PRE_LEN_IDX) ? LEN_HI : ZERO;
        end else begin
          state_next_s = PAD1;
        end
      end
      ZERO: begin
        word_s = 32'h0000_0000;
        if (load_s) begin
          emit_s       = 1'b1;
          state_next_s = (word_idx_r == PRE_LEN_IDX) ? LEN_HI : ZERO;
        end else begin
          state_next_s = ZERO;
        end
      end
      LEN_HI: begin
        word_s = bit_len_s[63:32];
        if (load_s) begin
          emit_s       = 1'b1;
          state_next_s = LEN_LO;
        end else begin
          state_next_s = LEN_HI;
        end
      end
      LEN_LO: begin
        word_s = bit_len_s[31:0];
        if (load_s) begin
          emit_s       = 1'b1;
          state_next_s = FLUSH;
        end else begin
          state_next_s = LEN_LO;
        end
      end
      FLUSH: begin
        if (final_ack_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = FLUSH;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Request capture and status flags; num_blocks holds until the next start
  always_ff @(posedge clk) begin
    if (reset) begin
      size_r       <= SIZE_W'(0);
      num_blocks_r <= BLK_W'(0);
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= final_ack_s;
      if (accept_start_s) begin
        size_r       <= size;
        num_blocks_r <= blk_s;
        busy_r       <= 1'b1;
      end else if (final_ack_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Output register stage and word/message/block counters
  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx_r       <= 4'h0;
      msg_cnt_r        <= SIZE_W'(0);
      blk_cnt_r        <= BLK_W'(0);
      out_valid_r      <= 1'b0;
      out_data_r       <= 32'h0000_0000;
      out_block_last_r <= 1'b0;
      out_msg_last_r   <= 1'b0;
    end else begin
      if (accept_start_s) begin
        word_idx_r <= 4'h0;
        msg_cnt_r  <= SIZE_W'(0);
        blk_cnt_r  <= BLK_W'(0);
      end
      if (emit_s) begin
        out_valid_r      <= 1'b1;
        out_data_r       <= word_s;
        out_block_last_r <= (word_idx_r == LAST_IDX);
        out_msg_last_r   <= (state_r == LEN_LO);
        word_idx_r       <= word_idx_r + 4'h1;
        if (word_idx_r == LAST_IDX) begin
          blk_cnt_r <= blk_cnt_r + BLK_W'(1);
        end
        if (state_r == MSG) begin
          msg_cnt_r <= msg_cnt_r + SIZE_W'(1);
        end
      end else if (out_ready) begin
        out_valid_r      <= 1'b0;
        out_block_last_r <= 1'b0;
        out_msg_last_r   <= 1'b0;
      end
    end
  end

  assign num_blocks     = num_blocks_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign in_ready       = in_ready_s;
  assign out_valid      = out_valid_r;
  assign out_data       = out_data_r;
  assign out_block_last = out_block_last_r;
  assign out_msg_last   = out_msg_last_r;

endmodule

// File: tb/tb_sha256_message_padder.sv
// -----------------------------------------------------------------------------
// tb_sha256_message_padder
// Directed bench for sha256_message_padder. A queue model builds the padded
// stream from SHA-256 padding rules (message, marker, zeros until the length
// is 14 mod 16, 64-bit bit-length); a negedge monitor checks every output
// handshake, output stability under backpressure, done timing, num_blocks
// stability and input over-consumption.
// -----------------------------------------------------------------------------
module tb_sha256_message_padder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] size;
  logic [12:0] num_blocks;
  logic        busy;
  logic        done;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_block_last;
  logic        out_msg_last;

  sha256_message_padder #(.SIZE_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .size           (size),
    .num_blocks     (num_blocks),
    .busy           (busy),
    .done           (done),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_block_last (out_block_last),
    .out_msg_last   (out_msg_last)
  );

  always #5 clk = ~clk;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] msg_mem[64];
  int          cur_nb, cur_size, in_idx, out_cnt, blk_seen;
  bit          done_flag, done_pending, prev_stall, mon_en;
  logic [31:0] prev_data;
  logic        prev_bl, prev_ml;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference padded stream from the padding rules
  task automatic build_model(input int sz);
    logic [63:0] bl;
    exp_q.delete();
    for (int i = 0; i < sz; i++) exp_q.push_back(msg_mem[i]);
    exp_q.push_back(32'h8000_0000);
    while ((exp_q.size() % 16) != 14) exp_q.push_back(32'h0);
    bl = 64'(sz) * 64'd32;
    exp_q.push_back(bl[63:32]);
    exp_q.push_back(bl[31:0]);
    cur_nb = exp_q.size() / 16;
  endtask

  // Compare process: checks take effect at the following posedge
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      prev_stall   = 1'b0;
      done_pending = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(prev_data));
        chk("stall_flags", 64'({out_block_last, out_msg_last}), 64'({prev_bl, prev_ml}));
      end
      chk("done", 64'(done), 64'(done_pending));
      if (done) done_flag = 1'b1;
      done_pending = 1'b0;
      if (busy) chk("num_blocks_stable", 64'(num_blocks), 64'(cur_nb));
      if (in_valid && in_ready) begin
        chk("in_overrun", 64'(in_idx < cur_size), 64'd1);
        in_idx++;
      end
      if (out_valid && out_ready) begin
        logic [31:0] e;
        chk("out_avail", 64'(exp_q.size() != 0), 64'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        chk("out_data", 64'(out_data), 64'(e));
        chk("out_block_last", 64'(out_block_last), 64'((out_cnt % 16) == 15));
        chk("out_msg_last", 64'(out_msg_last), 64'(exp_q.size() == 0));
        if (out_block_last) blk_seen++;
        if (out_msg_last) begin
          chk("blk_cnt_invariant", 64'(blk_seen), 64'(cur_nb));
          done_pending = 1'b1;
        end
        out_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_bl    = out_block_last;
      prev_ml    = out_msg_last;
    end
  end

  task automatic drive_inputs(input bit bp);
    in_valid  = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    in_data   = (in_idx < cur_size) ? msg_mem[in_idx] : 32'hDEAD_BEEF;
    out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic run_op(input int sz, input bit bp, input bit inject, input int abort_at,
                        input int nb_lit, input logic [31:0] last_lit);
    bit aborted = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) msg_mem[i] = 32'hC0DE_0000 + 32'(sz * 256 + i + 1);
    build_model(sz);
    chk("model_nb", 64'(cur_nb), 64'(nb_lit));
    chk("model_marker", 64'(exp_q[sz]), 64'h8000_0000);
    chk("model_last", 64'(exp_q[exp_q.size() - 1]), 64'(last_lit));
    cur_size  = sz;
    in_idx    = 0;
    out_cnt   = 0;
    blk_seen  = 0;
    done_flag = 1'b0;
    in_valid  = 1'b1;
    in_data   = msg_mem[0];
    out_ready = 1'b1;
    start     = 1'b1;
    size      = 16'(sz);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("num_blocks", 64'(num_blocks), 64'(nb_lit));
    chk("no_early_valid", 64'(out_valid), 64'd0);
    for (int cyc = 0; cyc < 1000 && !done_flag; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0 && !bp) chk("first_word_latency", 64'(out_valid), 64'd1);
      if (abort_at > 0 && out_cnt >= abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_num_blocks", 64'(num_blocks), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        aborted = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        break;
      end
      if (inject && cyc == 4) begin
        start = 1'b1;
        size  = 16'd999;
      end else if (inject && cyc == 5) begin
        start = 1'b0;
        size  = 16'(sz);
      end
      drive_inputs(bp);
    end
    if (!aborted) begin
      chk("completed", 64'(done_flag), 64'd1);
      chk("model_drained", 64'(exp_q.size()), 64'd0);
      chk("blocks_seen", 64'(blk_seen), 64'(nb_lit));
      chk("idle_after_done", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    size      = 16'd0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    mon_en    = 1'b0;
    cur_size  = 0;
    cur_nb    = 0;
    in_idx    = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_block_last", 64'(out_block_last), 64'd0);
    chk("rst_msg_last", 64'(out_msg_last), 64'd0);
    chk("rst_num_blocks", 64'(num_blocks), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    run_op(20, 1'b0, 1'b0, 0, 2, 32'h0000_0280);
    run_op(13, 1'b0, 1'b1, 0, 1, 32'h0000_01A0);
    run_op(14, 1'b0, 1'b0, 0, 2, 32'h0000_01C0);
    run_op(0,  1'b0, 1'b0, 0, 1, 32'h0000_0000);
    run_op(20, 1'b1, 1'b0, 0, 2, 32'h0000_0280);
    run_op(20, 1'b0, 1'b0, 7, 2, 32'h0000_0280);
    run_op(3,  1'b0, 1'b0, 0, 1, 32'h0000_0060);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
